i2c_scl_gen: RTL
================

// Module: i2c_scl_gen
// PURPOSE
//   Parametrised I2C SCL generator; successor to the fixed-mode clock generator in the I2C core.
//   - Produces an open-drain SCL at 100 kHz, 400 kHz or 1 MHz, or at a runtime custom divider.
//   - Supports slave clock stretching with a timeout.
//   - Emits phase strobes (SDA change point, SDA sample point) that the bit/byte engine uses.
// PARAMETERS
//   CLK_FREQ_HZ   50_000_000  system clock frequency, used to derive the fixed-mode half periods
//   DIV_W         16          width of the half-period counter and of custom_div
//   STRETCH_MAX   50_000      clk cycles allowed in a stretched high phase before timeout (1 ms)
// PORTS
//   clk           in   1      system clock
//   reset         in   1      asynchronous reset, active low
//   enable        in   1      1 = run SCL, 0 = finish current bit then release SCL
//   freq_mode     in   2      00=100k 01=400k 10=1M 11=custom_div
//   custom_div    in   DIV_W  half period in clk cycles when freq_mode=11
//   scl_in        in   1      sampled SCL pad level (asynchronous)
//   scl_oe        out  1      1 = pull SCL low; top level does scl = scl_oe ? 1'b0 : 1'bz
//   scl_rise      out  1      1-cycle pulse: SCL observed high after a release
//   scl_fall      out  1      1-cycle pulse: scl_oe asserted (start of a low phase)
//   sda_change    out  1      1-cycle pulse at the midpoint of the low phase
//   sda_sample    out  1      1-cycle pulse at the midpoint of the high phase
//   stretching    out  1      high while SCL is released but held low externally
//   busy          out  1      FSM not in IDLE
//   timeout       out  1      sticky stretch-timeout flag
// BEHAVIOUR
//   Reset (reset=0, asynchronous): FSM=IDLE, counters=0, synchroniser=11.
//     All outputs are 0, so SCL is released. Reset mid-phase releases SCL immediately.
//   Half period H (integer division, truncating):
//     - 00: CLK_FREQ_HZ/200_000   (250 @ 50 MHz)
//     - 01: CLK_FREQ_HZ/800_000   (62)
//     - 10: CLK_FREQ_HZ/2_000_000 (25)
//     - 11: custom_div, clamped to a minimum of 4.
//   H is latched on the IDLE->LOW transition only; freq_mode and custom_div changes mid-run are ignored.
//   scl_in passes a 2-flop synchroniser (scl_s), adding 2 cycles of latency.
//   FSM states:
//     IDLE:  scl_oe=0. On enable=1 and timeout=0: latch H, go LOW, pulse scl_fall.
//     LOW:   scl_oe=1; cnt runs 0..H-1.
//            cnt==H/2 -> pulse sda_change.
//            cnt==H-1 -> go WAIT (release SCL).
//     WAIT:  scl_oe=0.
//            scl_s==1 -> go HIGH, pulse scl_rise, clear scnt.
//            otherwise stretching=1 and scnt++.
//            scnt==STRETCH_MAX-1 -> set timeout, go IDLE.
//     HIGH:  scl_oe=0; cnt runs 0..H-1.
//            cnt==H/2 -> pulse sda_sample.
//            cnt==H-1 and enable=1 -> go LOW, pulse scl_fall.
//            cnt==H-1 and enable=0 -> go IDLE.
//     A 0..2-cycle WAIT is normal synchroniser delay, not a stretch.
//       stretching asserts only while scl_s==0 in WAIT.
//     If scl_s drops during HIGH (another master), continue counting; arbitration is not handled here.
//   Enable deassert in any active state:
//     - the current bit completes;
//     - SCL ends released high;
//     - no extra scl_fall occurs.
//   Timeout lockout:
//     - timeout stays 1 and the FSM stays in IDLE until enable=0;
//     - timeout clears on the first cycle enable is sampled 0.
//   Simultaneous events: the cnt==H-1 and cnt==H/2 pulses cannot coincide because H>=4.
//   Counters saturate and never wrap.
//   busy = (state != IDLE).
// TESTING
//   1. freq_mode=00, enable=1, scl_in tracks the pad:
//      -> scl_oe low for 250 cycles, high for 250+2 cycles; period 502 cycles.
//   2. freq_mode=01 -> low phase 62 cycles.
//      sda_change at low cnt 31; sda_sample at high cnt 31.
//   3. freq_mode=11, custom_div=3 -> H clamped to 4, low phase 4 cycles.
//      Change custom_div to 100 mid-run -> H stays 4 until IDLE.
//   4. Stretch: hold scl_in=0 for 100 cycles after release:
//      -> stretching high for about 100 cycles;
//      -> scl_rise 2 cycles after scl_in rises;
//      -> high phase then lasts full H.
//   5. STRETCH_MAX=1000, scl_in stuck 0:
//      -> timeout=1 after 1000 WAIT cycles, scl_oe=0, busy=0;
//      -> enable=0 clears timeout; enable=1 restarts with scl_fall.
//   6. Assert reset during LOW at cnt=10:
//      -> scl_oe=0 the same instant;
//      -> after release, IDLE until enable=1.

Source files
------------

// File: rtl/i2c_scl_gen.sv
// I2C SCL generator: open-drain SCL at a fixed or custom rate, slave clock stretching
// with a sticky timeout, and SDA change/sample phase strobes for the bit engine.
module i2c_scl_gen #(
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int DIV_W       = 16,
    parameter int STRETCH_MAX = 50_000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [1:0]       freq_mode,
    input  logic [DIV_W-1:0] custom_div,
    input  logic             scl_in,
    output logic             scl_oe,
    output logic             scl_rise,
    output logic             scl_fall,
    output logic             sda_change,
    output logic             sda_sample,
    output logic             stretching,
    output logic             busy,
    output logic             timeout
);
    localparam int SCNT_W = (STRETCH_MAX > 1) ? $clog2(STRETCH_MAX) : 1;
    localparam logic [DIV_W-1:0]  HALF_STD   = DIV_W'(CLK_FREQ_HZ / 200_000);
    localparam logic [DIV_W-1:0]  HALF_FAST  = DIV_W'(CLK_FREQ_HZ / 800_000);
    localparam logic [DIV_W-1:0]  HALF_FPLUS = DIV_W'(CLK_FREQ_HZ / 2_000_000);
    localparam logic [DIV_W-1:0]  HALF_MIN   = DIV_W'(4);
    localparam logic [SCNT_W-1:0] SCNT_LAST  = SCNT_W'(STRETCH_MAX - 1);
    localparam logic [SCNT_W-1:0] SYNC_GRACE = SCNT_W'(2);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOW  = 2'd1,
        ST_WAIT = 2'd2,
        ST_HIGH = 2'd3
    } state_t;

    state_t            state_r;
    logic [1:0]        sync_r;
    logic              scl_s;
    logic [DIV_W-1:0]  half_r;
    logic [DIV_W-1:0]  cnt_r;
    logic [DIV_W-1:0]  half_sel_s;
    logic [DIV_W-1:0]  cnt_inc_s;
    logic [DIV_W-1:0]  mid_m1_s;
    logic [DIV_W-1:0]  last_s;
    logic [SCNT_W-1:0] scnt_r;
    logic [SCNT_W-1:0] scnt_inc_s;

    assign scl_s      = sync_r[1];
    assign cnt_inc_s  = (cnt_r == {DIV_W{1'b1}}) ? cnt_r : cnt_r + DIV_W'(1);
    assign scnt_inc_s = (scnt_r == {SCNT_W{1'b1}}) ? scnt_r : scnt_r + SCNT_W'(1);
    // Strobes are registered, so they are armed one count early to land on cnt == H/2.
    assign mid_m1_s   = {1'b0, half_r[DIV_W-1:1]} - DIV_W'(1);
    assign last_s     = half_r - DIV_W'(1);

    // Half-period selection from the requested mode, custom divider clamped to 4.
    always_comb begin
        half_sel_s = HALF_STD;
        case (freq_mode)
            2'b00:   half_sel_s = HALF_STD;
            2'b01:   half_sel_s = HALF_FAST;
            2'b10:   half_sel_s = HALF_FPLUS;
            2'b11:   half_sel_s = (custom_div < HALF_MIN) ? HALF_MIN : custom_div;
            default: half_sel_s = HALF_STD;
        endcase
    end

    // Two-flop synchroniser for the asynchronous SCL pad level; idles high.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_r <= 2'b11;
        end else begin
            sync_r <= {sync_r[0], scl_in};
        end
    end

    // SCL phase FSM with registered pad enable, strobes, status and timeout.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r    <= ST_IDLE;
            half_r     <= '0;
            cnt_r      <= '0;
            scnt_r     <= '0;
            scl_oe     <= 1'b0;
            scl_rise   <= 1'b0;
            scl_fall   <= 1'b0;
            sda_change <= 1'b0;
            sda_sample <= 1'b0;
            stretching <= 1'b0;
            busy       <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            scl_rise   <= 1'b0;
            scl_fall   <= 1'b0;
            sda_change <= 1'b0;
            sda_sample <= 1'b0;
            stretching <= 1'b0;
            if (!enable) begin
                timeout <= 1'b0;
            end
            case (state_r)
                ST_IDLE: begin
                    scl_oe <= 1'b0;
                    busy   <= 1'b0;
                    if (enable && !timeout) begin
                        half_r   <= half_sel_s;
                        cnt_r    <= '0;
                        state_r  <= ST_LOW;
                        scl_oe   <= 1'b1;
                        scl_fall <= 1'b1;
                        busy     <= 1'b1;
                    end
                end
                ST_LOW: begin
                    if (cnt_r == mid_m1_s) begin
                        sda_change <= 1'b1;
                    end
                    if (cnt_r == last_s) begin
                        state_r <= ST_WAIT;
                        scl_oe  <= 1'b0;
                        scnt_r  <= '0;
                    end else begin
                        cnt_r <= cnt_inc_s;
                    end
                end
                ST_WAIT: begin
                    if (scl_s) begin
                        state_r  <= ST_HIGH;
                        scl_rise <= 1'b1;
                        scnt_r   <= '0;
                        cnt_r    <= '0;
                    end else if (scnt_r == SCNT_LAST) begin
                        state_r <= ST_IDLE;
                        timeout <= 1'b1;
                        busy    <= 1'b0;
                        scnt_r  <= '0;
                    end else begin
                        // The first cycles of WAIT are synchroniser latency, not a stretch.
                        scnt_r     <= scnt_inc_s;
                        stretching <= (scnt_r >= SYNC_GRACE);
                    end
                end
                ST_HIGH: begin
                    if (cnt_r == mid_m1_s) begin
                        sda_sample <= 1'b1;
                    end
                    if (cnt_r == last_s) begin
                        cnt_r <= '0;
                        if (enable) begin
                            state_r  <= ST_LOW;
                            scl_oe   <= 1'b1;
                            scl_fall <= 1'b1;
                        end else begin
                            state_r <= ST_IDLE;
                            busy    <= 1'b0;
                        end
                    end else begin
                        cnt_r <= cnt_inc_s;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    scl_oe  <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end
endmodule
